// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I load/store unit in front of a word-wide memory
// with combinational read and synchronous write. Sub-word stores are done
// as read-modify-write. Faulting requests go straight to the response
// state and leave memory untouched.
module mem_access_unit #(
    parameter int unsigned MEM_WORDS = 32'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  offs_q, offs_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        fault_q, fault_d;

    // A request faults on an illegal funct3, a misaligned half/word or a
    // word index beyond the populated memory.
    function automatic logic req_faults(input logic we, input logic [2:0] f3,
                                        input logic [31:0] addr);
        logic legal;
        case (f3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = (addr[0] == 1'b0);
            3'b010:  legal = (addr[1:0] == 2'b00);
            3'b100:  legal = !we;
            3'b101:  legal = !we && (addr[0] == 1'b0);
            default: legal = 1'b0;
        endcase
        return !legal || ({2'b00, addr[31:2]} >= MEM_WORDS);
    endfunction

    // Pick the addressed byte/half out of a word and sign- or zero-extend.
    function automatic logic [31:0] load_extract(input logic [2:0] f3,
                                                 input logic [31:0] word,
                                                 input logic [1:0] offs);
        logic [31:0] shifted;
        shifted = word >> {offs, 3'b000};
        case (f3)
            3'b000:  return {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  return {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  return word;
            3'b100:  return {24'h000000, shifted[7:0]};
            3'b101:  return {16'h0000, shifted[15:0]};
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Insert the low byte/half of the store data into its lane of the old word.
    function automatic logic [31:0] store_merge(input logic [2:0] f3,
                                                input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [1:0] offs);
        logic [31:0] mask;
        case (f3)
            3'b000:  mask = 32'h0000_00FF << {offs, 3'b000};
            3'b001:  mask = 32'h0000_FFFF << {offs, 3'b000};
            default: mask = 32'hFFFF_FFFF;
        endcase
        return (word & ~mask) | ((wdata << {offs, 3'b000}) & mask);
    endfunction

    // State and request registers; reset drops any request in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            offs_q   <= 2'b00;
            addr_q   <= 32'h0000_0000;
            data_q   <= 32'h0000_0000;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            offs_q   <= offs_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            fault_q  <= fault_d;
        end
    end

    // Next-state logic: accept in IDLE, read/merge in READ, write, respond.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        offs_d   = offs_q;
        addr_d   = addr_q;
        data_d   = data_q;
        fault_d  = fault_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    offs_d   = req_addr[1:0];
                    data_d   = req_wdata;
                    if (req_faults(req_we, req_funct3, req_addr)) begin
                        fault_d = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        fault_d = 1'b0;
                        // The memory address only moves for real accesses.
                        addr_d  = {req_addr[31:2], 2'b00};
                        if (req_we && (req_funct3 == 3'b010)) begin
                            state_d = S_WRITE;
                        end else begin
                            state_d = S_READ;
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (we_q) begin
                    data_d  = store_merge(funct3_q, mem_read_data, data_q, offs_q);
                    state_d = S_WRITE;
                end else begin
                    data_d  = load_extract(funct3_q, mem_read_data, offs_q);
                    state_d = S_RESP;
                end
            end
            S_WRITE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready        = (state_q == S_IDLE);
    assign resp_valid       = (state_q == S_RESP);
    assign resp_fault       = (state_q == S_RESP) && fault_q;
    assign resp_rdata       = ((state_q == S_RESP) && !fault_q && !we_q) ? data_q : 32'h0000_0000;
    assign mem_address      = addr_q;
    assign mem_write_data   = (state_q == S_WRITE) ? data_q : 32'h0000_0000;
    // Reset blocks the write even if it arrives during the WRITE cycle.
    assign mem_write_enable = (state_q == S_WRITE) && !rst;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: behavioural word memory plus a reference
// model of load/store semantics built from byte-lane arithmetic.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_fault;
    logic [31:0] resp_rdata, mem_address, mem_write_data, mem_read_data;
    logic        mem_write_enable;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    logic [31:0] last_addr;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_WORDS(255)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
    );

    assign mem_read_data = mem[mem_address[9:2]];
    always @(posedge clk) if (mem_write_enable) mem[mem_address[9:2]] <= mem_write_data;

    // Reference: fault rules, extension and lane merge from plain arithmetic.
    function automatic void ref_model(input logic we, input logic [2:0] f3,
            input logic [31:0] a, input logic [31:0] wd, output logic flt,
            output logic [31:0] rd, output int lat, output int wcyc, output logic [31:0] wword);
        logic legal, mis, oor;
        int size, sh;
        logic [31:0] word, mask, part;
        if (we) legal = (f3 <= 3'd2);
        else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        size = int'(f3[1:0]);
        mis  = (size == 1 && a[0]) || (size == 2 && a[1:0] != 2'b00);
        oor  = (a >> 2) >= 32'd255;
        flt  = !legal || mis || oor;
        rd = 32'h0; lat = 1; wcyc = 0; wword = 32'h0;
        if (flt) return;
        word = ref_mem[a[9:2]];
        sh   = 8 * int'(a[1:0]);
        mask = (size == 0) ? 32'hFF : (size == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
        if (!we) begin
            part = (word >> sh) & mask;
            if (!f3[2] && size != 2 && part > (mask >> 1)) part = part | ~mask;
            rd = part; lat = 2;
        end else begin
            wword = (word & ~(mask << sh)) | ((wd << sh) & (mask << sh));
            if (size == 2) begin lat = 2; wcyc = 1; end
            else           begin lat = 3; wcyc = 2; end
        end
    endfunction

    // Issue one request from IDLE and observe the DUT until one cycle past its response.
    task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
            input logic [31:0] wd, output int lat, output logic [31:0] rd, output logic flt,
            output int nwr, output int wcyc, output logic [31:0] wdat, output logic [31:0] wadr,
            output logic [31:0] resp_addr, output logic busy_ready, output logic rdy_acc,
            output logic extra, output logic leak);
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        rdy_acc = req_ready;
        lat = 0; rd = 32'h0; flt = 1'b0; nwr = 0; wcyc = 0; wdat = 32'h0; wadr = 32'h0;
        resp_addr = 32'h0; busy_ready = 1'b0; extra = 1'b0; leak = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (mem_write_enable) begin nwr++; wcyc = k; wdat = mem_write_data; wadr = mem_address; end
            else if (mem_write_data !== 32'h0) leak = 1'b1;
            if (req_ready) busy_ready = 1'b1;
            if (resp_valid) begin
                lat = k; rd = resp_rdata; flt = resp_fault; resp_addr = mem_address;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat != 0) begin
            @(posedge clk); #1;
            extra = resp_valid;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        checks++; if ({resp_valid, resp_fault, mem_write_enable} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 000", {resp_valid, resp_fault, mem_write_enable}); end
        checks++; if ({resp_rdata, mem_address, mem_write_data} !== 96'h0) begin
            errors++; $display("FAIL reset_data: got %h %h %h expected zeros", resp_rdata, mem_address, mem_write_data); end
        rst = 1'b0;
        @(posedge clk); #1;
        last_addr = 32'h0;
    endtask

    typedef struct {
        logic we; logic [2:0] f3; logic [31:0] a; logic [31:0] wd;
        logic [31:0] rd; logic flt; int lat; int nwr; int wcyc; logic [31:0] wdat;
    } vec_t;

    task automatic test_directed();
        vec_t v [12];
        int lat, nwr, wcyc;
        logic [31:0] rd, wdat, wadr, raddr;
        logic flt, busy, racc, extra, leak;
        v[0]  = '{1'b0, 3'b010, 32'h4,   32'h0,  32'h1234_5678, 1'b0, 2, 0, 0, 32'h0};
        v[1]  = '{1'b0, 3'b000, 32'h3,   32'h0,  32'hFFFF_FFDE, 1'b0, 2, 0, 0, 32'h0};
        v[2]  = '{1'b0, 3'b100, 32'h3,   32'h0,  32'h0000_00DE, 1'b0, 2, 0, 0, 32'h0};
        v[3]  = '{1'b0, 3'b001, 32'h2,   32'h0,  32'hFFFF_DEAD, 1'b0, 2, 0, 0, 32'h0};
        v[4]  = '{1'b0, 3'b101, 32'h0,   32'h0,  32'h0000_BEEF, 1'b0, 2, 0, 0, 32'h0};
        v[5]  = '{1'b1, 3'b000, 32'h5,   32'hAA, 32'h0,         1'b0, 3, 1, 2, 32'h1234_AA78};
        v[6]  = '{1'b0, 3'b010, 32'h4,   32'h0,  32'h1234_AA78, 1'b0, 2, 0, 0, 32'h0};
        v[7]  = '{1'b0, 3'b010, 32'h6,   32'h0,  32'h0,         1'b1, 1, 0, 0, 32'h0};
        v[8]  = '{1'b1, 3'b001, 32'h3,   32'h0,  32'h0,         1'b1, 1, 0, 0, 32'h0};
        v[9]  = '{1'b0, 3'b010, 32'h3FC, 32'h0,  32'h0,         1'b1, 1, 0, 0, 32'h0};
        v[10] = '{1'b0, 3'b011, 32'h0,   32'h0,  32'h0,         1'b1, 1, 0, 0, 32'h0};
        v[11] = '{1'b1, 3'b010, 32'h8,   32'hA5A5_5A5A, 32'h0,  1'b0, 2, 1, 1, 32'hA5A5_5A5A};
        for (int i = 0; i < 12; i++) begin
            drive_req(v[i].we, v[i].f3, v[i].a, v[i].wd, lat, rd, flt, nwr, wcyc, wdat, wadr,
                      raddr, busy, racc, extra, leak);
            if (!v[i].flt) last_addr = {v[i].a[31:2], 2'b00};
            if (v[i].we && !v[i].flt) ref_mem[v[i].a[9:2]] = v[i].wdat;
            checks++; if (lat != v[i].lat) begin errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, v[i].lat); end
            checks++; if (rd !== v[i].rd) begin errors++; $display("FAIL dir%0d_rdata: got %h expected %h", i, rd, v[i].rd); end
            checks++; if (flt !== v[i].flt) begin errors++; $display("FAIL dir%0d_fault: got %b expected %b", i, flt, v[i].flt); end
            checks++; if (nwr != v[i].nwr) begin errors++; $display("FAIL dir%0d_writes: got %0d expected %0d", i, nwr, v[i].nwr); end
            if (v[i].nwr != 0) begin
                checks++; if (wcyc != v[i].wcyc) begin errors++; $display("FAIL dir%0d_wcycle: got %0d expected %0d", i, wcyc, v[i].wcyc); end
                checks++; if (wdat !== v[i].wdat) begin errors++; $display("FAIL dir%0d_wdata: got %h expected %h", i, wdat, v[i].wdat); end
                checks++; if (wadr !== {v[i].a[31:2], 2'b00}) begin errors++; $display("FAIL dir%0d_waddr: got %h expected %h", i, wadr, {v[i].a[31:2], 2'b00}); end
            end
            checks++; if (raddr !== last_addr) begin errors++; $display("FAIL dir%0d_addr_hold: got %h expected %h", i, raddr, last_addr); end
            checks++; if ({racc, busy, extra, leak} !== 4'b1000) begin
                errors++; $display("FAIL dir%0d_handshake: got %b expected 1000", i, {racc, busy, extra, leak}); end
        end
    endtask

    task automatic test_reset_mid_write();
        logic seen;
        req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h2; req_wdata = 32'h0000_CAFE; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (mem_write_enable !== 1'b1) begin errors++; $display("FAIL rstw_in_write: got %b expected 1", mem_write_enable); end
        rst = 1'b1;
        #1;
        checks++; if (mem_write_enable !== 1'b0) begin errors++; $display("FAIL rstw_gated: got %b expected 0", mem_write_enable); end
        @(posedge clk); #1;
        rst = 1'b0;
        last_addr = 32'h0;
        seen = 1'b0;
        repeat (4) begin
            if (resp_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstw_no_resp: got %b expected 0", seen); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstw_idle: got %b expected 1", req_ready); end
        checks++; if (mem[0] !== ref_mem[0]) begin errors++; $display("FAIL rstw_word0: got %h expected %h", mem[0], ref_mem[0]); end
    endtask

    task automatic test_back_to_back();
        logic [6:0] rdy, rv;
        logic [31:0] d2, d5;
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h4; req_wdata = 32'h0; req_valid = 1'b1;
        d2 = 32'h0; d5 = 32'h0;
        for (int c = 0; c < 7; c++) begin
            rdy[c] = req_ready; rv[c] = resp_valid;
            if (c == 2) d2 = resp_rdata;
            if (c == 5) d5 = resp_rdata;
            @(posedge clk); #1;
            if (c == 3) req_valid = 1'b0;
        end
        last_addr = 32'h4;
        checks++; if (rdy !== 7'b1001001) begin errors++; $display("FAIL b2b_ready: got %b expected 1001001", rdy); end
        checks++; if (rv !== 7'b0100100) begin errors++; $display("FAIL b2b_resp: got %b expected 0100100", rv); end
        checks++; if ({d2, d5} !== {ref_mem[1], ref_mem[1]}) begin
            errors++; $display("FAIL b2b_rdata: got %h %h expected %h", d2, d5, ref_mem[1]); end
    endtask

    task automatic test_random();
        logic we, flt, eflt, busy, racc, extra, leak;
        logic [2:0] f3;
        logic [31:0] a, wd, rd, erd, wdat, wadr, raddr, ewd;
        int lat, elat, nwr, wcyc, ewcyc, mode;
        for (int i = 0; i < 200; i++) begin
            we = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7)); wd = $urandom;
            mode = $urandom_range(0, 7);
            if (mode == 0)      a = {20'h0, 10'($urandom_range(250, 260)), 2'($urandom_range(0, 3))};
            else if (mode == 1) a = $urandom;
            else                a = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            ref_model(we, f3, a, wd, eflt, erd, elat, ewcyc, ewd);
            drive_req(we, f3, a, wd, lat, rd, flt, nwr, wcyc, wdat, wadr, raddr, busy, racc, extra, leak);
            if (!eflt) last_addr = {a[31:2], 2'b00};
            if (we && !eflt) ref_mem[a[9:2]] = ewd;
            checks++; if (lat != elat) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, elat); end
            checks++; if ({flt, rd} !== {eflt, erd}) begin
                errors++; $display("FAIL rnd%0d_result: got %b/%h expected %b/%h", i, flt, rd, eflt, erd); end
            checks++; if (nwr != ((ewcyc != 0) ? 1 : 0) || wcyc != ewcyc) begin
                errors++; $display("FAIL rnd%0d_wcount: got %0d@%0d expected write cycle %0d", i, nwr, wcyc, ewcyc); end
            if (ewcyc != 0) begin
                checks++; if ({wdat, wadr} !== {ewd, last_addr}) begin
                    errors++; $display("FAIL rnd%0d_write: got %h@%h expected %h@%h", i, wdat, wadr, ewd, last_addr); end
            end
            checks++; if ({raddr, racc, busy, extra, leak} !== {last_addr, 4'b1000}) begin
                errors++; $display("FAIL rnd%0d_misc: got %h %b expected %h 1000", i, raddr, {racc, busy, extra, leak}, last_addr); end
        end
    endtask

    task automatic test_final_memory();
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL final_memory: got %0d differing words expected 0", bad); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[0] = 32'hDEAD_BEEF; ref_mem[0] = 32'hDEAD_BEEF;
        mem[1] = 32'h1234_5678; ref_mem[1] = 32'h1234_5678;
        test_reset();
        test_directed();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        test_final_memory();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
